id_slice: RTL and testbench

Instruction-decode stage of the 5-stage 16-bit pipelined CPU. It sits between IF/ID and the EX stage. It owns the 16×16 register file and decodes the instruction into WB/M/EX control bundles. It detects load-use and write-back hazards and stalls IF, and it registers everything into the ID/EX pipeline register that feeds EX. Latency is one cycle from a valid IF/ID instruction to ID/EX outputs.

---
 rtl/id_slice.sv | 228 ++++++++++++++++++++++
 tb/tb_id_slice.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_slice.sv
// Purpose : decode stage of the 16-bit CPU; owns the 16x16 register file and fills the ID/EX register.
// Latency : one cycle from a valid IF/ID instruction to the ID/EX outputs.
// Backpressure: raises combinational stall (IF and IF/ID hold) on load-use, WB-distance or halt; ID/EX gets a bubble.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   instr, pc_plus2, if_valid    IF/ID slot contents
//   flush                        branch unit kills the instruction in decode
//   wb_we, wb_rd, wb_data        register-file write port from WB
//   stall                        combinational hold request to IF
//   valid, WB, M, EX             ID/EX control bundles (WB={reg_write,mem_to_reg}, M={mem_read,mem_write},
//                                EX={ALUSrc[1:0],shamt[3:0],ALUOp[3:0]})
//   reg0, reg1, rs, rt, rd       operand data and register numbers for forwarding
//   imm, offset                  zero-extended imm8 (or PC+2 for JAL) / sign-extended imm4 << 1
//   halted                       HLT has been decoded
//
// Build option: ID_WB_BYPASS_EN makes the register file write-through, removing the WB-distance stall.
module id_slice (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic [15:0] pc_plus2,
    input  logic        if_valid,
    input  logic        flush,
    input  logic        wb_we,
    input  logic [3:0]  wb_rd,
    input  logic [15:0] wb_data,
    output logic        stall,
    output logic        valid,
    output logic [1:0]  WB,
    output logic [1:0]  M,
    output logic [9:0]  EX,
    output logic [15:0] reg0,
    output logic [15:0] reg1,
    output logic [3:0]  rs,
    output logic [3:0]  rt,
    output logic [3:0]  rd,
    output logic [15:0] imm,
    output logic [15:0] offset,
    output logic        halted
);

    typedef enum logic {S_RUN, S_HALT} state_t;

    state_t      state_q, state_d;
    logic [15:0] rf [16];

    logic [3:0]  opcode, f_rd, f_rs, f_rt;
    logic [3:0]  src_a, src_b;
    logic        a_used, b_used;
    logic [15:0] rdata_a, rdata_b;

    logic        d_valid;
    logic [1:0]  d_wb, d_m, d_alusrc;
    logic [3:0]  d_shamt, d_aluop, d_rs, d_rt, d_rd;
    logic [15:0] d_imm, d_offset;

    logic        lu_hit, wb_hit, hazard, issue;

    assign opcode = instr[15:12];
    assign f_rd   = instr[11:8];
    assign f_rs   = instr[7:4];
    assign f_rt   = instr[3:0];
    assign halted = (state_q == S_HALT);

    // Register file: R0 is never written, so it always reads back as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) rf[i] <= 16'h0000;
        end else if (wb_we && (wb_rd != 4'h0)) begin
            rf[wb_rd] <= wb_data;
        end
    end

    always_comb begin
        rdata_a = (src_a == 4'h0) ? 16'h0000 : rf[src_a];
        rdata_b = (src_b == 4'h0) ? 16'h0000 : rf[src_b];
`ifdef ID_WB_BYPASS_EN
        if (wb_we && (wb_rd != 4'h0) && (wb_rd == src_a)) rdata_a = wb_data;
        if (wb_we && (wb_rd != 4'h0) && (wb_rd == src_b)) rdata_b = wb_data;
`endif
    end

    // Decode: src_a feeds reg0, src_b feeds reg1; the *_used flags mark real dependencies.
    always_comb begin
        d_valid  = 1'b0;
        d_wb     = 2'b00;
        d_m      = 2'b00;
        d_alusrc = 2'b00;
        d_shamt  = 4'h0;
        d_aluop  = 4'h0;
        d_rs     = 4'h0;
        d_rt     = 4'h0;
        d_rd     = 4'h0;
        d_imm    = 16'h0000;
        d_offset = 16'h0000;
        src_a    = f_rs;
        src_b    = f_rt;
        a_used   = 1'b0;
        b_used   = 1'b0;
        case (opcode)
            4'h0, 4'h1, 4'h2, 4'h3: begin
                d_valid = 1'b1;
                d_wb    = 2'b10;
                d_aluop = opcode;
                d_rs    = f_rs;
                d_rt    = f_rt;
                d_rd    = f_rd;
                a_used  = 1'b1;
                b_used  = 1'b1;
            end
            4'h5, 4'h6, 4'h7: begin
                d_valid = 1'b1;
                d_wb    = 2'b10;
                d_aluop = opcode;
                d_shamt = f_rt;
                d_rs    = f_rs;
                d_rd    = f_rd;
                a_used  = 1'b1;
            end
            4'h8: begin
                d_valid  = 1'b1;
                d_wb     = 2'b11;
                d_m      = 2'b10;
                d_alusrc = 2'b10;
                d_rs     = f_rs;
                d_rd     = f_rd;
                d_offset = {{11{instr[3]}}, instr[3:0], 1'b0};
                a_used   = 1'b1;
            end
            4'h9: begin
                // Store data comes from the rd field, so it is presented on the rt path.
                d_valid  = 1'b1;
                d_m      = 2'b01;
                d_alusrc = 2'b10;
                d_rs     = f_rs;
                d_rt     = f_rd;
                d_offset = {{11{instr[3]}}, instr[3:0], 1'b0};
                src_b    = f_rd;
                a_used   = 1'b1;
                b_used   = 1'b1;
            end
            4'hA, 4'hB: begin
                // LHB/LLB merge into the old destination value, which is read as operand A.
                d_valid  = 1'b1;
                d_wb     = 2'b10;
                d_alusrc = 2'b01;
                d_aluop  = opcode;
                d_rs     = f_rd;
                d_rd     = f_rd;
                d_imm    = {8'h00, instr[7:0]};
                src_a    = f_rd;
                a_used   = 1'b1;
            end
            4'hD: begin
                d_valid  = 1'b1;
                d_wb     = 2'b10;
                d_alusrc = 2'b01;
                d_rd     = 4'hF;
                d_imm    = pc_plus2;
            end
            default: begin
                // B, JR, HLT and the undefined opcode all leave a bubble behind.
            end
        endcase
    end

    assign lu_hit = valid && M[1] && (rd != 4'h0) &&
                    ((a_used && (src_a == rd)) || (b_used && (src_b == rd)));
`ifdef ID_WB_BYPASS_EN
    assign wb_hit = 1'b0;
`else
    assign wb_hit = wb_we && (wb_rd != 4'h0) &&
                    ((a_used && (src_a == wb_rd)) || (b_used && (src_b == wb_rd)));
`endif
    assign hazard = if_valid && (lu_hit || wb_hit);
    assign issue  = !flush && (state_q == S_RUN) && if_valid && !hazard && d_valid;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_RUN;
        else     state_q <= state_d;
    end

    // Priority: rst > flush > halted > hazard.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        if (rst) begin
            stall = 1'b0;
        end else if (flush) begin
            stall = 1'b0;
        end else if (state_q == S_HALT) begin
            stall = 1'b1;
        end else begin
            stall = hazard;
            if (if_valid && (opcode == 4'hF)) state_d = S_HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !issue) begin
            valid  <= 1'b0;
            WB     <= 2'b00;
            M      <= 2'b00;
            EX     <= 10'h000;
            reg0   <= 16'h0000;
            reg1   <= 16'h0000;
            rs     <= 4'h0;
            rt     <= 4'h0;
            rd     <= 4'h0;
            imm    <= 16'h0000;
            offset <= 16'h0000;
        end else begin
            valid  <= 1'b1;
            WB     <= d_wb;
            M      <= d_m;
            EX     <= {d_alusrc, d_shamt, d_aluop};
            reg0   <= a_used ? rdata_a : 16'h0000;
            reg1   <= b_used ? rdata_b : 16'h0000;
            rs     <= d_rs;
            rt     <= d_rt;
            rd     <= d_rd;
            imm    <= d_imm;
            offset <= d_offset;
        end
    end

endmodule

// File: tb/tb_id_slice.sv
// Purpose : self-checking bench for id_slice against a behavioural model.
// Latency : model predicts ID/EX one edge after each drive; stall checked in the drive cycle.
// Backpressure: bench honours no backpressure itself; the model predicts stall/bubbles.
module tb_id_slice;

    logic        clk = 1'b0;
    logic        rst, if_valid, flush, wb_we;
    logic [15:0] instr, pc_plus2, wb_data;
    logic [3:0]  wb_rd;
    logic        stall, valid, halted;
    logic [1:0]  WB, M;
    logic [9:0]  EX;
    logic [15:0] reg0, reg1, imm, offset;
    logic [3:0]  rs, rt, rd;

    always #5 clk = ~clk;

    id_slice dut (
        .clk(clk), .rst(rst), .instr(instr), .pc_plus2(pc_plus2), .if_valid(if_valid),
        .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall(stall), .valid(valid), .WB(WB), .M(M), .EX(EX),
        .reg0(reg0), .reg1(reg1), .rs(rs), .rt(rt), .rd(rd),
        .imm(imm), .offset(offset), .halted(halted)
    );

    int checks   = 0;
    int failures = 0;
    logic last_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] mr [16];
    logic        e_valid, e_halted;
    logic [1:0]  e_wb, e_m;
    logic [9:0]  e_ex;
    logic [15:0] e_reg0, e_reg1, e_imm, e_off;
    logic [3:0]  e_rs, e_rt, e_rd;

    function automatic logic [15:0] m_read(input logic [3:0] a);
        if (a == 4'h0) return 16'h0000;
`ifdef ID_WB_BYPASS_EN
        if (wb_we && wb_rd == a) return wb_data;
`endif
        return mr[a];
    endfunction

    // Registers an instruction really reads.
    function automatic bit uses(input logic [15:0] ins, input logic [3:0] r);
        int op = int'(ins[15:12]);
        if (op <= 3)              return (ins[7:4] == r) || (ins[3:0] == r);
        if (op >= 5 && op <= 8)   return ins[7:4] == r;
        if (op == 9)              return (ins[7:4] == r) || (ins[11:8] == r);
        if (op == 10 || op == 11) return ins[11:8] == r;
        return 1'b0;
    endfunction

    function automatic bit m_hazard();
        bit lu, wbh;
        if (!if_valid) return 1'b0;
        lu  = e_valid && e_m[1] && (e_rd != 0) && uses(instr, e_rd);
        wbh = 1'b0;
`ifndef ID_WB_BYPASS_EN
        wbh = wb_we && (wb_rd != 0) && uses(instr, wb_rd);
`endif
        return lu || wbh;
    endfunction

    function automatic bit m_stall();
        if (rst || flush) return 1'b0;
        if (e_halted)     return 1'b1;
        return m_hazard();
    endfunction

    task automatic model_edge();
        int op, v;
        bit go;
        logic [3:0] fd, fs, ft;
        if (rst) begin
            for (int i = 0; i < 16; i++) mr[i] = 16'h0000;
            {e_valid, e_halted, e_wb, e_m, e_ex} = '0;
            {e_reg0, e_reg1, e_imm, e_off, e_rs, e_rt, e_rd} = '0;
            return;
        end
        op = int'(instr[15:12]);
        fd = instr[11:8]; fs = instr[7:4]; ft = instr[3:0];
        v  = int'(ft); if (v > 7) v -= 16;
        go = !flush && !e_halted && if_valid && !m_hazard();
        {e_valid, e_wb, e_m, e_ex} = '0;
        {e_reg0, e_reg1, e_imm, e_off, e_rs, e_rt, e_rd} = '0;
        if (go) begin
            if (op <= 3) begin
                e_valid = 1; e_wb = 2'b10; e_ex = 10'(op);
                e_reg0 = m_read(fs); e_reg1 = m_read(ft); e_rs = fs; e_rt = ft; e_rd = fd;
            end else if (op >= 5 && op <= 7) begin
                e_valid = 1; e_wb = 2'b10; e_ex = 10'(op) | (10'(ft) << 4);
                e_reg0 = m_read(fs); e_rs = fs; e_rd = fd;
            end else if (op == 8) begin
                e_valid = 1; e_wb = 2'b11; e_m = 2'b10; e_ex = 10'h200;
                e_reg0 = m_read(fs); e_rs = fs; e_rd = fd; e_off = 16'(v * 2);
            end else if (op == 9) begin
                e_valid = 1; e_m = 2'b01; e_ex = 10'h200;
                e_reg0 = m_read(fs); e_reg1 = m_read(fd); e_rs = fs; e_rt = fd; e_off = 16'(v * 2);
            end else if (op == 10 || op == 11) begin
                e_valid = 1; e_wb = 2'b10; e_ex = 10'h100 | 10'(op);
                e_reg0 = m_read(fd); e_rs = fd; e_rd = fd; e_imm = {8'h00, instr[7:0]};
            end else if (op == 13) begin
                e_valid = 1; e_wb = 2'b10; e_ex = 10'h100; e_rd = 4'hF; e_imm = pc_plus2;
            end
        end
        if (!flush && !e_halted && if_valid && op == 15) e_halted = 1;
        if (wb_we && wb_rd != 0) mr[wb_rd] = wb_data;
    endtask

    // One cycle: drive on negedge, check stall, model the edge, check ID/EX.
    task automatic step(input logic [15:0] i, input logic [15:0] pc, input bit iv, input bit fl,
                        input bit we, input logic [3:0] wr, input logic [15:0] wd, input bit r);
        @(negedge clk);
        instr = i; pc_plus2 = pc; if_valid = iv; flush = fl;
        wb_we = we; wb_rd = wr; wb_data = wd; rst = r;
        #1;
        last_stall = stall;
        chk("stall", 32'(stall), 32'(m_stall()));
        @(posedge clk);
        model_edge();
        #1;
        chk("valid",  32'(valid),  32'(e_valid));
        chk("WB",     32'(WB),     32'(e_wb));
        chk("M",      32'(M),      32'(e_m));
        chk("EX",     32'(EX),     32'(e_ex));
        chk("reg0",   32'(reg0),   32'(e_reg0));
        chk("reg1",   32'(reg1),   32'(e_reg1));
        chk("rs",     32'(rs),     32'(e_rs));
        chk("rt",     32'(rt),     32'(e_rt));
        chk("rd",     32'(rd),     32'(e_rd));
        chk("imm",    32'(imm),    32'(e_imm));
        chk("offset", 32'(offset), 32'(e_off));
        chk("halted", 32'(halted), 32'(e_halted));
    endtask

    initial begin
        logic [15:0] ri;
        int          pick;
        rst = 1; instr = 0; pc_plus2 = 0; if_valid = 0; flush = 0;
        wb_we = 0; wb_rd = 0; wb_data = 0;

        step(16'h0000, 16'h0, 0, 0, 0, 4'h0, 16'h0, 1);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);

        // ADD R3,R1,R2 with R1=5, R2=7
        step(16'h0000, 16'h0, 0, 0, 1, 4'h1, 16'd5, 0);
        step(16'h0000, 16'h0, 0, 0, 1, 4'h2, 16'd7, 0);
        step(16'h0312, 16'h0, 1, 0, 0, 4'h0, 16'h0, 0);
        chk("add_valid", 32'(valid), 32'h1);
        chk("add_reg0", 32'(reg0), 32'd5);
        chk("add_reg1", 32'(reg1), 32'd7);
        chk("add_rd", 32'(rd), 32'h3);
        chk("add_ex", 32'(EX), 32'h0);
        chk("add_wb", 32'(WB), 32'h2);

        // LW R4,R1,-2 then ADD R5,R4,R2: one bubble
        step(16'h841E, 16'h0, 1, 0, 0, 4'h0, 16'h0, 0);
        chk("lw_offset", 32'(offset), 32'hFFFC);
        chk("lw_m", 32'(M), 32'h2);
        step(16'h0542, 16'h0, 1, 0, 0, 4'h0, 16'h0, 0);
        chk("lu_stall", 32'(last_stall), 32'h1);
        chk("lu_bubble", 32'(valid), 32'h0);
        step(16'h0542, 16'h0, 1, 0, 0, 4'h0, 16'h0, 0);
        chk("lu_retry_stall", 32'(last_stall), 32'h0);
        chk("lu_retry_rs", 32'(rs), 32'h4);

        // SUB R7,R6,R0 while WB writes R6
        step(16'h1760, 16'h0, 1, 0, 1, 4'h6, 16'h1234, 0);
`ifdef ID_WB_BYPASS_EN
        chk("byp_stall", 32'(last_stall), 32'h0);
        chk("byp_reg0", 32'(reg0), 32'h1234);
`else
        chk("wbh_stall", 32'(last_stall), 32'h1);
        chk("wbh_bubble", 32'(valid), 32'h0);
        step(16'h1760, 16'h0, 1, 0, 0, 4'h0, 16'h0, 0);
        chk("wbh_reg0", 32'(reg0), 32'h1234);
`endif

        // LHB R2,0xAB with R2=00CD
        step(16'h0000, 16'h0, 0, 0, 1, 4'h2, 16'h00CD, 0);
        step(16'hA2AB, 16'h0, 1, 0, 0, 4'h0, 16'h0, 0);
        chk("lhb_reg0", 32'(reg0), 32'h00CD);
        chk("lhb_imm", 32'(imm), 32'h00AB);
        chk("lhb_ex", 32'(EX), 32'h10A);

        // JAL
        step(16'hD000, 16'h0040, 1, 0, 0, 4'h0, 16'h0, 0);
        chk("jal_rd", 32'(rd), 32'hF);
        chk("jal_reg0", 32'(reg0), 32'h0);
        chk("jal_imm", 32'(imm), 32'h0040);
        chk("jal_wb", 32'(WB), 32'h2);

        // flush during load-use hazard
        step(16'h841E, 16'h0, 1, 0, 0, 4'h0, 16'h0, 0);
        step(16'h0542, 16'h0, 1, 1, 0, 4'h0, 16'h0, 0);
        chk("flush_stall", 32'(last_stall), 32'h0);
        chk("flush_bubble", 32'(valid), 32'h0);

        // HLT then reset
        step(16'hF000, 16'h0, 1, 0, 0, 4'h0, 16'h0, 0);
        chk("hlt_halted", 32'(halted), 32'h1);
        step(16'h0312, 16'h0, 1, 0, 0, 4'h0, 16'h0, 0);
        chk("hlt_stall", 32'(last_stall), 32'h1);
        chk("hlt_bubble", 32'(valid), 32'h0);
        step(16'h0312, 16'h0, 1, 0, 0, 4'h0, 16'h0, 0);
        step(16'h0312, 16'h0, 1, 0, 0, 4'h0, 16'h0, 1);
        chk("hrst_halted", 32'(halted), 32'h0);
        chk("hrst_valid", 32'(valid), 32'h0);

        // randomized phase
        for (int n = 0; n < 3000; n++) begin
            pick = int'($urandom_range(0, 99));
            ri[15:12] = (pick < 2) ? 4'hF : 4'($urandom_range(0, 14));
            ri[11:8]  = 4'($urandom_range(0, 7));
            ri[7:4]   = 4'($urandom_range(0, 7));
            ri[3:0]   = 4'($urandom_range(0, 15));
            step(ri, 16'($urandom),
                 $urandom_range(0, 99) < 90, $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 50, 4'($urandom_range(0, 7)), 16'($urandom),
                 $urandom_range(0, 99) < 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
